mimo_channel_tx: RTL

MIMO_CHANNEL_TX -- requirements
Module: mimo_channel_tx

---
 rtl/mimo_pkg.sv | 15 +
 rtl/mimo_channel_tx_if.sv | 24 ++
 rtl/mimo_mac.sv | 11 +
 rtl/mimo_channel_tx.sv | 105 ++++++++++
 4 files changed

// File: rtl/mimo_pkg.sv
// rtl/mimo_pkg.sv - shared constants and types for the MIMO transmit/precalc/solver chain
package mimo_pkg;
    localparam int N_ANT  = 4;
    localparam int DATA_W = 32;

    typedef logic [31:0]             word_t;
    typedef word_t [0:N_ANT-1]       vec_t;
    typedef vec_t  [0:N_ANT-1]       mat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mimo_channel_tx_if.sv
// rtl/mimo_channel_tx_if.sv - job input / result output handshake bundle for mimo_channel_tx
interface mimo_channel_tx_if;
    import mimo_pkg::*;

    logic  in_valid;
    logic  in_ready;
    mat_t  H_matrix;
    vec_t  x_vec;
    vec_t  noise_vec;
    logic  out_valid;
    logic  out_ready;
    vec_t  signal_receive;
    logic  busy;

    modport master (
        output in_valid, H_matrix, x_vec, noise_vec, out_ready,
        input  in_ready, out_valid, signal_receive, busy
    );

    modport slave (
        input  in_valid, H_matrix, x_vec, noise_vec, out_ready,
        output in_ready, out_valid, signal_receive, busy
    );
endinterface

// File: rtl/mimo_mac.sv
// rtl/mimo_mac.sv - combinational 32-bit multiply-add, result modulo 2^32
module mimo_mac
    import mimo_pkg::*;
(
    input  word_t acc,
    input  word_t a,
    input  word_t b,
    output word_t sum
);
    assign sum = acc + a * b;
endmodule

// File: rtl/mimo_channel_tx.sv
// rtl/mimo_channel_tx.sv - computes r = H*x + n with one multiply-add per cycle
module mimo_channel_tx #(
    parameter int N_ANT  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mimo_channel_tx_if.slave  bus
);
    import mimo_pkg::word_t;
    import mimo_pkg::vec_t;
    import mimo_pkg::mat_t;
    import mimo_pkg::state_t;
    import mimo_pkg::IDLE;
    import mimo_pkg::MAC;
    import mimo_pkg::DONE;

    localparam logic [1:0] LAST = 2'(N_ANT - 1);

    state_t             state;
    state_t             state_next;
    logic [1:0]         row;
    logic [1:0]         col;
    logic [DATA_W-1:0]  acc;
    word_t              acc_next;
    mat_t               h_reg;
    vec_t               x_reg;
    vec_t               n_reg;
    vec_t               result;
    logic               valid_q;

    mimo_mac u_mac (
        .acc (acc),
        .a   (h_reg[row][col]),
        .b   (x_reg[col]),
        .sum (acc_next)
    );

    always_comb begin
        state_next         = state;
        bus.in_ready       = 1'b0;
        bus.busy           = 1'b0;
        bus.out_valid      = valid_q;
        bus.signal_receive = result;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = MAC;
            end
            MAC: begin
                bus.busy = 1'b1;
                if (row == LAST && col == LAST) state_next = DONE;
            end
            DONE: begin
                if (valid_q && bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The first DONE cycle only raises out_valid, so the result is presented
    // one edge after the last row write and the handshake happens after that.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            row     <= 2'd0;
            col     <= 2'd0;
            acc     <= '0;
            h_reg   <= '0;
            x_reg   <= '0;
            n_reg   <= '0;
            result  <= '0;
            valid_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        h_reg <= bus.H_matrix;
                        x_reg <= bus.x_vec;
                        n_reg <= bus.noise_vec;
                        acc   <= bus.noise_vec[0];
                        row   <= 2'd0;
                        col   <= 2'd0;
                    end
                end
                MAC: begin
                    if (col == LAST) begin
                        result[row] <= acc_next;
                        col         <= 2'd0;
                        row         <= row + 2'd1;
                        acc         <= n_reg[row + 2'd1];
                    end else begin
                        col <= col + 2'd1;
                        acc <= acc_next;
                    end
                end
                DONE: begin
                    valid_q <= !(valid_q && bus.out_ready);
                end
                default: ;
            endcase
        end
    end
endmodule
